// File: rtl/spi_mem_cmd_engine.sv
// SPI frame command engine: opcode/address decode, auto-incrementing burst access
// across N byte-wide RAM banks, a read-only signature bank and sticky error status.
module spi_mem_cmd_engine #(
   parameter int          NUM_BANKS  = 20,
   parameter int          BANK_AW    = 9,
   parameter int          ADDR_BYTES = 2,
   parameter logic [31:0] SIGNATURE  = 32'h1CE40A01
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cs,
   input  logic                 i_rx_valid,
   input  logic [7:0]           i_rx_byte,
   output logic                 o_tx_valid,
   output logic [7:0]           o_tx_byte,
   input  logic                 i_tx_ready,
   output logic [NUM_BANKS-1:0] o_mem_sel,
   output logic                 o_mem_en,
   output logic                 o_mem_we,
   output logic [BANK_AW-1:0]   o_mem_addr,
   output logic [7:0]           o_mem_wdata,
   input  logic [7:0]           i_mem_rdata,
   output logic [7:0]           o_status
);
   localparam int AW = 8 * ADDR_BYTES;
   localparam int BW = AW - BANK_AW;
   localparam int CW = $clog2(ADDR_BYTES) + 1;

   localparam logic [7:0] OP_WRITE  = 8'h02;
   localparam logic [7:0] OP_READ   = 8'h03;
   localparam logic [7:0] OP_STATUS = 8'h05;
   localparam logic [7:0] OP_CLEAR  = 8'h06;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WR_DATA, S_RD_ISSUE, S_RD_WAIT, S_RD_PRESENT, S_STATUS, S_IGNORE
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [AW-1:0]        r_addr, w_addr_nxt, w_addr_shift, w_acc_addr;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic                 r_is_rd, w_is_rd_nxt;
   logic                 r_err_oor, w_err_oor_nxt, r_err_opc, w_err_opc_nxt;
   logic                 r_tx_valid, w_tx_valid_nxt;
   logic [7:0]           r_tx_byte, w_tx_byte_nxt, w_rd_byte;
   logic [NUM_BANKS-1:0] r_mem_sel, w_mem_sel_nxt;
   logic                 r_mem_en, w_mem_en_nxt, r_mem_we, w_mem_we_nxt;
   logic [BANK_AW-1:0]   r_mem_addr, w_mem_addr_nxt;
   logic [7:0]           r_mem_wdata, w_mem_wdata_nxt;
   logic [BW-1:0]        w_acc_bank, w_cur_bank;
   logic                 w_acc, w_acc_we, w_hs;

   function automatic logic [7:0] sig_byte(input logic [BANK_AW-1:0] offs);
      logic [7:0] b;
      if (offs >= BANK_AW'(4)) begin
         b = 8'h00;
      end else begin
         case (offs[1:0])
            2'd0:    b = SIGNATURE[31:24];
            2'd1:    b = SIGNATURE[23:16];
            2'd2:    b = SIGNATURE[15:8];
            default: b = SIGNATURE[7:0];
         endcase
      end
      return b;
   endfunction

   assign w_addr_shift = (r_addr << 4'd8) | AW'(i_rx_byte);
   assign w_cur_bank   = r_addr[AW-1:BANK_AW];
   assign w_hs         = r_tx_valid & i_tx_ready;

   // Read data source for the current address: RAM, signature, or zero when out of range.
   always_comb begin
      if (w_cur_bank < BW'(NUM_BANKS)) begin
         w_rd_byte = i_mem_rdata;
      end else if (w_cur_bank == BW'(NUM_BANKS)) begin
         w_rd_byte = sig_byte(r_addr[BANK_AW-1:0]);
      end else begin
         w_rd_byte = 8'h00;
      end
   end

   // Next-state and next-output logic; memory outputs are decoded from the requested access.
   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_cnt_nxt       = r_cnt;
      w_is_rd_nxt     = r_is_rd;
      w_err_oor_nxt   = r_err_oor;
      w_err_opc_nxt   = r_err_opc;
      w_tx_valid_nxt  = 1'b0;
      w_tx_byte_nxt   = r_tx_byte;
      w_acc           = 1'b0;
      w_acc_we        = 1'b0;
      w_acc_addr      = r_addr;
      w_mem_en_nxt    = 1'b0;
      w_mem_we_nxt    = 1'b0;
      w_mem_sel_nxt   = {NUM_BANKS{1'b0}};
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      if (i_cs) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_rx_valid) begin
                  w_cnt_nxt = {CW{1'b0}};
                  case (i_rx_byte)
                     OP_WRITE:  begin w_state_nxt = S_ADDR; w_is_rd_nxt = 1'b0; end
                     OP_READ:   begin w_state_nxt = S_ADDR; w_is_rd_nxt = 1'b1; end
                     OP_STATUS: begin
                        w_state_nxt    = S_STATUS;
                        w_tx_valid_nxt = 1'b1;
                        w_tx_byte_nxt  = {r_err_oor, r_err_opc, 6'b000000};
                     end
                     OP_CLEAR:  begin
                        w_state_nxt   = S_IGNORE;
                        w_err_oor_nxt = 1'b0;
                        w_err_opc_nxt = 1'b0;
                     end
                     default:   begin w_state_nxt = S_IGNORE; w_err_opc_nxt = 1'b1; end
                  endcase
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_ADDR: begin
               if (i_rx_valid) begin
                  w_addr_nxt = w_addr_shift;
                  w_cnt_nxt  = r_cnt + CW'(1'b1);
                  if (r_cnt == CW'(ADDR_BYTES - 1)) begin
                     if (r_is_rd) begin
                        w_state_nxt = S_RD_ISSUE;
                        w_acc       = 1'b1;
                        w_acc_addr  = w_addr_shift;
                     end else begin
                        w_state_nxt = S_WR_DATA;
                     end
                  end else begin
                     w_state_nxt = S_ADDR;
                  end
               end else begin
                  w_state_nxt = S_ADDR;
               end
            end
            S_WR_DATA: begin
               if (i_rx_valid) begin
                  w_acc      = 1'b1;
                  w_acc_we   = 1'b1;
                  w_addr_nxt = r_addr + AW'(1'b1);
               end else begin
                  w_acc = 1'b0;
               end
            end
            S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
               w_state_nxt    = S_RD_PRESENT;
               w_tx_valid_nxt = 1'b1;
               w_tx_byte_nxt  = w_rd_byte;
            end
            S_RD_PRESENT: begin
               if (w_hs) begin
                  w_state_nxt = S_RD_ISSUE;
                  w_addr_nxt  = r_addr + AW'(1'b1);
                  w_acc       = 1'b1;
                  w_acc_addr  = r_addr + AW'(1'b1);
               end else begin
                  w_tx_valid_nxt = 1'b1;
               end
            end
            S_STATUS: begin
               w_tx_valid_nxt = 1'b1;
               w_tx_byte_nxt  = {r_err_oor, r_err_opc, 6'b000000};
            end
            S_IGNORE: w_state_nxt = S_IGNORE;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
      w_acc_bank = w_acc_addr[AW-1:BANK_AW];
      if (w_acc && (w_acc_bank < BW'(NUM_BANKS))) begin
         w_mem_en_nxt    = 1'b1;
         w_mem_we_nxt    = w_acc_we;
         w_mem_addr_nxt  = w_acc_addr[BANK_AW-1:0];
         w_mem_wdata_nxt = w_acc_we ? i_rx_byte : r_mem_wdata;
         for (int i = 0; i < NUM_BANKS; i++) begin
            w_mem_sel_nxt[i] = (w_acc_bank == BW'(i));
         end
      end else if (w_acc && (w_acc_bank > BW'(NUM_BANKS))) begin
         w_err_oor_nxt = 1'b1;
      end else begin
         w_mem_en_nxt = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_addr      <= {AW{1'b0}};
         r_cnt       <= {CW{1'b0}};
         r_is_rd     <= 1'b0;
         r_err_oor   <= 1'b0;
         r_err_opc   <= 1'b0;
         r_tx_valid  <= 1'b0;
         r_tx_byte   <= 8'h00;
         r_mem_sel   <= {NUM_BANKS{1'b0}};
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {BANK_AW{1'b0}};
         r_mem_wdata <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_cnt       <= w_cnt_nxt;
         r_is_rd     <= w_is_rd_nxt;
         r_err_oor   <= w_err_oor_nxt;
         r_err_opc   <= w_err_opc_nxt;
         r_tx_valid  <= w_tx_valid_nxt;
         r_tx_byte   <= w_tx_byte_nxt;
         r_mem_sel   <= w_mem_sel_nxt;
         r_mem_en    <= w_mem_en_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
      end
   end

   assign o_tx_valid  = r_tx_valid;
   assign o_tx_byte   = r_tx_byte;
   assign o_mem_sel   = r_mem_sel;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_status    = {r_err_oor, r_err_opc, 6'b000000};
endmodule

// File: tb/tb_spi_mem_cmd_engine.sv
// Directed bench for spi_mem_cmd_engine: a table of frames with hand-computed results,
// a byte-RAM model on the bank port, and hand-written abort/latency/reset sequences.
module tb_spi_mem_cmd_engine;
   localparam int NB  = 20;
   localparam int BAW = 9;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b0;
   logic           i_cs = 1'b1;
   logic           i_rx_valid = 1'b0;
   logic [7:0]     i_rx_byte = 8'h00;
   logic           i_tx_ready = 1'b0;
   logic [7:0]     i_mem_rdata;
   logic           o_tx_valid, o_mem_en, o_mem_we;
   logic [7:0]     o_tx_byte, o_mem_wdata, o_status;
   logic [NB-1:0]  o_mem_sel;
   logic [BAW-1:0] o_mem_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   spi_mem_cmd_engine dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_cs(i_cs),
      .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
      .o_tx_valid(o_tx_valid), .o_tx_byte(o_tx_byte), .i_tx_ready(i_tx_ready),
      .o_mem_sel(o_mem_sel), .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
      .o_status(o_status)
   );

   // Memory model and strobe monitor
   typedef struct { int bank; int addr; logic we; logic [7:0] wdata; } strobe_t;
   strobe_t    slog[$];
   logic [7:0] mem [0:NB*512-1];
   int         n_strobe = 0;
   int         sel_bad  = 0;

   function automatic int sel_index(input logic [NB-1:0] s);
      for (int i = 0; i < NB; i++) if (s[i]) return i;
      return -1;
   endfunction

   always @(posedge i_clk) begin
      if (o_mem_en) begin
         n_strobe <= n_strobe + 1;
         slog.push_back('{sel_index(o_mem_sel), int'(o_mem_addr), o_mem_we, o_mem_wdata});
         if (!$onehot(o_mem_sel)) sel_bad <= sel_bad + 1;
         if (sel_index(o_mem_sel) >= 0) begin
            if (o_mem_we) mem[sel_index(o_mem_sel)*512 + int'(o_mem_addr)] <= o_mem_wdata;
            else          i_mem_rdata <= mem[sel_index(o_mem_sel)*512 + int'(o_mem_addr)];
         end
      end else if (o_mem_sel != '0) begin
         sel_bad <= sel_bad + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge i_clk); i_rx_valid = 1'b1; i_rx_byte = b;
      @(negedge i_clk); i_rx_valid = 1'b0;
   endtask

   task automatic frame_start();
      @(negedge i_clk); i_cs = 1'b0;
   endtask

   task automatic frame_end();
      @(negedge i_clk); i_cs = 1'b1;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic wait_tx(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (o_tx_valid) begin ok = 1'b1; break; end
         @(negedge i_clk);
      end
   endtask

   task automatic get_byte(input string name, output logic [7:0] b);
      bit ok;
      wait_tx(ok);
      check({name, " tx timeout"}, 32'(ok), 32'd1);
      b = o_tx_byte;
      if (ok) begin
         i_tx_ready = 1'b1;
         @(negedge i_clk); i_tx_ready = 1'b0;
      end
   endtask

   task automatic status_frame(input string name, input logic [7:0] exp);
      logic [7:0] b;
      frame_start();
      send_byte(8'h05);
      get_byte(name, b);
      check({name, " status"}, 32'(b), 32'(exp));
      frame_end();
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [15:0] addr;
      int          n;
      logic [39:0] data;  // write payload, first byte in [39:32]
      logic [39:0] exp;   // expected tx bytes, first byte in [39:32]
      logic [7:0]  st;    // expected status after the frame
   } vec_t;

   localparam int NV = 15;
   vec_t vt [NV];

   initial begin
      logic [7:0]  b;
      logic [15:0] a;
      int          base, exp_cnt, sbase;
      string       nm;
      bit          ok;

      vt[0]  = '{8'h02, 16'h01FE, 4, 40'hAABBCCDD00, 40'h0,          8'h00};
      vt[1]  = '{8'h03, 16'h01FE, 4, 40'h0,          40'hAABBCCDD00, 8'h00};
      vt[2]  = '{8'h03, 16'h2800, 5, 40'h0,          40'h1CE40A0100, 8'h00};
      vt[3]  = '{8'h02, 16'h2A00, 1, 40'h5500000000, 40'h0,          8'h80};
      vt[4]  = '{8'h06, 16'h0000, 0, 40'h0,          40'h0,          8'h00};
      vt[5]  = '{8'h7F, 16'h0000, 0, 40'h0,          40'h0,          8'h40};
      vt[6]  = '{8'h05, 16'h0000, 3, 40'h0,          40'h4040400000, 8'h40};
      vt[7]  = '{8'h06, 16'h0000, 0, 40'h0,          40'h0,          8'h00};
      vt[8]  = '{8'h02, 16'hFFFF, 2, 40'h1122000000, 40'h0,          8'h80};
      vt[9]  = '{8'h06, 16'h0000, 0, 40'h0,          40'h0,          8'h00};
      vt[10] = '{8'h02, 16'h27FF, 1, 40'h5A00000000, 40'h0,          8'h00};
      vt[11] = '{8'h03, 16'h27FF, 3, 40'h0,          40'h5A1CE40000, 8'h00};
      vt[12] = '{8'h03, 16'h2803, 2, 40'h0,          40'h0100000000, 8'h00};
      vt[13] = '{8'h03, 16'h0000, 1, 40'h0,          40'h2200000000, 8'h00};
      vt[14] = '{8'h03, 16'h0200, 2, 40'h0,          40'hCCDD000000, 8'h00};

      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("reset tx_valid", 32'(o_tx_valid), 32'd0);
      check("reset tx_byte",  32'(o_tx_byte),  32'd0);
      check("reset mem",      {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, 32'd0);
      check("reset mem_sel",  32'(o_mem_sel),  32'd0);
      check("reset status",   32'(o_status),   32'd0);

      for (int v = 0; v < NV; v++) begin
         nm = $sformatf("v%0d", v);
         base = slog.size();
         frame_start();
         send_byte(vt[v].op);
         if (vt[v].op == 8'h02 || vt[v].op == 8'h03) begin
            send_byte(vt[v].addr[15:8]);
            send_byte(vt[v].addr[7:0]);
         end
         if (vt[v].op == 8'h02) begin
            for (int i = 0; i < vt[v].n; i++) send_byte(vt[v].data[39-8*i -: 8]);
            repeat (2) @(negedge i_clk);
            exp_cnt = 0;
            for (int i = 0; i < vt[v].n; i++) begin
               a = vt[v].addr + 16'(i);
               if (int'(a >> 9) < NB) begin
                  if (base + exp_cnt < slog.size()) begin
                     check($sformatf("%s wr%0d bank", nm, i), 32'(slog[base+exp_cnt].bank), 32'(a >> 9));
                     check($sformatf("%s wr%0d addr", nm, i), 32'(slog[base+exp_cnt].addr), 32'(a & 16'h01FF));
                     check($sformatf("%s wr%0d we", nm, i), 32'(slog[base+exp_cnt].we), 32'd1);
                     check($sformatf("%s wr%0d data", nm, i), 32'(slog[base+exp_cnt].wdata),
                           32'(vt[v].data[39-8*i -: 8]));
                  end
                  exp_cnt++;
               end
            end
            check({nm, " write strobes"}, 32'(slog.size() - base), 32'(exp_cnt));
         end else if (vt[v].op == 8'h03 || vt[v].op == 8'h05) begin
            for (int i = 0; i < vt[v].n; i++) begin
               sbase = n_strobe;
               get_byte($sformatf("%s rd%0d", nm, i), b);
               check($sformatf("%s rd%0d byte", nm, i), 32'(b), 32'(vt[v].exp[39-8*i -: 8]));
               if (vt[v].op == 8'h03) begin
                  a = vt[v].addr + 16'(i);
                  check($sformatf("%s rd%0d strobes", nm, i), 32'(n_strobe - sbase),
                        (int'(a >> 9) < NB) ? 32'd1 : 32'd0);
               end
            end
         end
         frame_end();
         check({nm, " o_status"}, 32'(o_status), 32'(vt[v].st));
         status_frame(nm, vt[v].st);
      end

      // Byte arriving with chip select high is dropped
      @(negedge i_clk); i_rx_valid = 1'b1; i_rx_byte = 8'h7F;
      @(negedge i_clk); i_rx_valid = 1'b0;
      status_frame("cs-high byte", 8'h00);

      // tx byte held without ready, dropped by chip select
      frame_start();
      send_byte(8'h03); send_byte(8'h02); send_byte(8'h00);
      wait_tx(ok);
      check("hold tx timeout", 32'(ok), 32'd1);
      repeat (3) @(negedge i_clk);
      check("hold tx_valid", 32'(o_tx_valid), 32'd1);
      check("hold tx_byte",  32'(o_tx_byte),  32'hCC);
      i_cs = 1'b1;
      @(negedge i_clk);
      check("cs drops tx_valid", 32'(o_tx_valid), 32'd0);
      repeat (2) @(negedge i_clk);

      // Set an error so reset has something to clear
      frame_start(); send_byte(8'h7F); frame_end();
      check("opc err before reset", 32'(o_status), 32'h40);

      // Abort after one address byte, then READ 0x0000 with latency and reset checks
      frame_start(); send_byte(8'h03); send_byte(8'h12); frame_end();
      frame_start();
      send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
      check("t6 strobe en",   {o_mem_en, o_mem_we}, 32'h2);
      check("t6 strobe sel",  32'(o_mem_sel),  32'h00001);
      check("t6 strobe addr", 32'(o_mem_addr), 32'h000);
      check("t6 no tx c+1",   32'(o_tx_valid), 32'd0);
      @(negedge i_clk);
      check("t6 no tx c+2",   32'(o_tx_valid), 32'd0);
      @(negedge i_clk);
      check("t6 tx c+3",      32'(o_tx_valid), 32'd1);
      check("t6 tx byte",     32'(o_tx_byte),  32'h22);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("t6 rst tx",     {o_tx_valid, o_tx_byte}, 32'd0);
      check("t6 rst mem",    {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, 32'd0);
      check("t6 rst sel",    32'(o_mem_sel), 32'd0);
      check("t6 rst status", 32'(o_status),  32'd0);
      i_rst = 1'b1;
      i_cs  = 1'b1;
      repeat (2) @(negedge i_clk);

      check("mem_sel one-hot and idle-zero", 32'(sel_bad), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end
endmodule
